mic_capture: RTL
================

Name: mic_capture

Overview:
- Upstream front end for the signal-delay stage.
- Periodically runs a serial ADC conversion frame and assembles the serial bits into a sample.
- Truncates the sample to DATA_WIDTH and presents it on mic_signal.
- Emits a one-cycle sample_valid strobe, which the delay stage uses as its counter enable and RAM write enable, so one RAM entry is written per audio sample.

Parameters:
- DATA_WIDTH, 8: width of mic_signal; equals the delay stage data width.
- ADC_WIDTH, 12: number of data bits per ADC frame, MSB-first; must be >= DATA_WIDTH.
- LEAD_BITS, 2: discarded leading bits per frame (sample/null bits).
- CLK_DIV, 4: clk cycles per adc_sclk half-period; must be >= 1.
- SAMPLE_PERIOD, 256: clk cycles between conversion triggers; must be >= 2*CLK_DIV*(LEAD_BITS+ADC_WIDTH)+4.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-low.
- en, input, 1: enables the sample timer (and so new conversions).
- adc_sdo, input, 1: serial data from the ADC.
- adc_cs_n, output, 1: ADC chip select, active-low.
- adc_sclk, output, 1: ADC serial clock.
- mic_signal, output, DATA_WIDTH: latest captured sample, unsigned.
- sample_valid, output, 1: one-cycle strobe; mic_signal is new this cycle.
- busy, output, 1: high while a conversion frame is in progress.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, timer=0, adc_cs_n=1, adc_sclk=0, mic_signal=0, sample_valid=0, busy=0, shift register and counters cleared. Reset mid-frame aborts the frame immediately with no sample_valid.
- FRAME_BITS = LEAD_BITS + ADC_WIDTH.
- Sample timer:
  - Counts 0..SAMPLE_PERIOD-1 and wraps, advancing only when en=1.
  - When timer==SAMPLE_PERIOD-1 and en=1 (the trigger cycle), the next state is CONVERT.
  - While en=0 the timer holds; a frame already in progress still completes.
- States:
  - IDLE: adc_cs_n=1, adc_sclk=0, busy=0. Goes to CONVERT on a trigger.
  - CONVERT: adc_cs_n=0, busy=1. A half-period counter hc runs 0..CLK_DIV-1. When hc==CLK_DIV-1, adc_sclk toggles and hc returns to 0. The first rising edge of adc_sclk occurs CLK_DIV cycles after adc_cs_n falls.
  - Sampling: on each clk edge where adc_sclk goes 0->1, adc_sdo is shifted into the shift register LSB, and the bit counter increments.
  - Leaving CONVERT: on the falling toggle that follows the FRAME_BITS-th rising edge, go to DONE (adc_sclk=0). Total time in CONVERT is 2*CLK_DIV*FRAME_BITS cycles.
  - DONE (one cycle): adc_cs_n=1, busy=0, sample_valid=1. mic_signal = bits [ADC_WIDTH-1 : ADC_WIDTH-DATA_WIDTH] of the last ADC_WIDTH bits shifted (truncation, no rounding). Lead bits never reach mic_signal. Then go to IDLE.
- mic_signal is registered and holds its value between DONE cycles. sample_valid is high only in DONE.
- Latency: trigger cycle T; adc_cs_n low from T+1; DONE/sample_valid at T+1+2*CLK_DIV*FRAME_BITS.
- Triggers cannot occur while busy, given the SAMPLE_PERIOD constraint. The implementation still ignores any trigger seen outside IDLE.
- en falling during CONVERT: the frame completes normally and sample_valid still fires. en rising restarts counting from the held timer value.

Test Plan:
- Reset: hold rst=0 with random adc_sdo -> adc_cs_n=1, adc_sclk=0, mic_signal=0, sample_valid=0, busy=0. Assert rst=0 mid-frame -> all outputs return to reset values within the same cycle, and no strobe follows.
- Basic capture (defaults): en=1; ADC model drives lead bits 2'b11, then 12'hA5C MSB-first on sclk rising edges -> mic_signal=8'hA5, sample_valid one cycle.
- Frame timing (defaults): sample_valid exactly 112 cycles after adc_cs_n falls; exactly 14 sclk rising edges per frame; sclk high/low phases 4 cycles each; adc_cs_n low for 112 cycles.
- Periodicity: en=1 continuous, data 12'hFFF then 12'h00F -> mic_signal 8'hFF then 8'h00. Strobes are 256 cycles apart.
- en gating: drop en midway through a frame -> the frame completes with a strobe, then no further frames. Re-raise en after 100 cycles -> the next trigger comes when the timer reaches 255, counting from its held value.
- Integration: connect sample_valid to the delay stage en and wr, with offset=3 -> the delayed output equals the mic_signal from three strobes earlier.

Source files
------------

// File: rtl/mic_capture.sv
// rtl/mic_capture.sv - periodic serial ADC frame capture, truncated sample plus one-cycle valid strobe
module mic_capture #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADC_WIDTH     = 12,
    parameter int LEAD_BITS     = 2,
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  adc_sdo,
    output logic                  adc_cs_n,
    output logic                  adc_sclk,
    output logic [DATA_WIDTH-1:0] mic_signal,
    output logic                  sample_valid,
    output logic                  busy
);
    localparam int FRAME_BITS = LEAD_BITS + ADC_WIDTH;
    localparam int TW         = $clog2(SAMPLE_PERIOD);
    localparam int HW         = $clog2(CLK_DIV + 1);
    localparam int BW         = $clog2(FRAME_BITS + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [HW-1:0] HC_LAST    = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BITS_LAST  = BW'(FRAME_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [TW-1:0]           timer_q;
    logic [TW-1:0]           timer_d;
    logic [HW-1:0]           hc_q;
    logic [BW-1:0]           bitcnt_q;
    logic [ADC_WIDTH-1:0]    shift_q;
    logic                    cs_n_q;
    logic                    sclk_q;
    logic                    valid_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   mic_q;
    logic                    trigger;

    always_comb begin
        timer_d = timer_q;
        if (en) begin
            timer_d = (timer_q == TIMER_LAST) ? '0 : timer_q + 1'b1;
        end
    end

    assign trigger = en && (timer_q == TIMER_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // Lead bits enter the shift register first and fall off its top, so only
    // the last ADC_WIDTH bits remain when the frame ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            hc_q     <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            mic_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        state_q  <= S_CONVERT;
                        cs_n_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        sclk_q   <= 1'b0;
                        hc_q     <= '0;
                        bitcnt_q <= '0;
                        shift_q  <= '0;
                    end
                end
                S_CONVERT: begin
                    if (hc_q == HC_LAST) begin
                        hc_q <= '0;
                        if (!sclk_q) begin
                            sclk_q   <= 1'b1;
                            shift_q  <= {shift_q[ADC_WIDTH-2:0], adc_sdo};
                            bitcnt_q <= bitcnt_q + 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            if (bitcnt_q == BITS_LAST) begin
                                state_q <= S_DONE;
                                cs_n_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                valid_q <= 1'b1;
                                mic_q   <= shift_q[ADC_WIDTH-1 -: DATA_WIDTH];
                            end
                        end
                    end else begin
                        hc_q <= hc_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign adc_cs_n     = cs_n_q;
    assign adc_sclk     = sclk_q;
    assign mic_signal   = mic_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;

endmodule
